// File: rtl/tug3_demux_rx.sv
// Receive-side TUG-3 demultiplexer: frame alignment, channel de-interleave,
// column-0 overhead suppression and per-channel BIP-8 generation/checking.
module tug3_demux_rx #(
    parameter int WIDTH   = 8,
    parameter int NCH     = 3,
    parameter int NCOL    = 86,
    parameter int NROW    = 9,
    parameter int BIP_ROW = 0,
    parameter int BIP_COL = 1,
    parameter int CHW     = (NCH > 1) ? $clog2(NCH) : 1,
    parameter int ECW     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             rxsof,
    input  logic [WIDTH-1:0] tug3din,
    output logic [WIDTH-1:0] tug3dout,
    output logic [CHW-1:0]   dout_ch,
    output logic             data_vld,
    output logic [WIDTH-1:0] tug3bip8,
    output logic [CHW-1:0]   bip_ch,
    output logic             bip_vld,
    output logic [ECW-1:0]   bip_errcnt,
    output logic             err_vld,
    output logic             realign,
    output logic             in_sync
);

    localparam int COLW = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam int ROWW = (NROW > 1) ? $clog2(NROW) : 1;
    localparam logic [CHW-1:0]  CH_LAST  = CHW'(NCH - 1);
    localparam logic [COLW-1:0] COL_LAST = COLW'(NCOL - 1);
    localparam logic [ROWW-1:0] ROW_LAST = ROWW'(NROW - 1);
    localparam logic [COLW-1:0] COL_BIP  = COLW'(BIP_COL);
    localparam logic [ROWW-1:0] ROW_BIP  = ROWW'(BIP_ROW);

    typedef enum logic {HUNT, SYNC} state_t;

    state_t            state, state_nxt;
    logic [CHW-1:0]    ch;
    logic [COLW-1:0]   col;
    logic [ROWW-1:0]   row;
    logic [WIDTH-1:0]  acc  [NCH];
    logic [WIDTH-1:0]  expd [NCH];
    logic [NCH-1:0]    expv;

    logic              proc_p0, sof_p0, realign_p0, last_p0, chk_p0;
    logic [CHW-1:0]    pch_p0;
    logic [COLW-1:0]   pcol_p0;
    logic [ROWW-1:0]   prow_p0;
    logic [WIDTH-1:0]  bip_p0;

    function automatic logic [ECW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [ECW-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) n = n + ECW'(v[i]);
        return n;
    endfunction

    // stage p0: position decode of the incoming byte (rxsof forces 0,0,0)
    always_comb begin
        state_nxt  = state;
        sof_p0     = en & rxsof;
        proc_p0    = en & ((state == SYNC) | rxsof);
        realign_p0 = sof_p0 & (state == SYNC) &
                     ((ch != '0) | (col != '0) | (row != '0));
        pch_p0     = sof_p0 ? '0 : ch;
        pcol_p0    = sof_p0 ? '0 : col;
        prow_p0    = sof_p0 ? '0 : row;
        last_p0    = proc_p0 & (prow_p0 == ROW_LAST) & (pcol_p0 == COL_LAST);
        chk_p0     = proc_p0 & (prow_p0 == ROW_BIP) & (pcol_p0 == COL_BIP) &
                     ~realign_p0 & expv[pch_p0];
        bip_p0     = (realign_p0 ? '0 : acc[pch_p0]) ^ tug3din;
        if (state == HUNT && sof_p0) state_nxt = SYNC;
    end

    assign in_sync = (state == SYNC);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= HUNT;
            ch    <= '0;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_nxt;
            if (proc_p0) begin
                if (pch_p0 == CH_LAST) begin
                    ch <= '0;
                    if (pcol_p0 == COL_LAST) begin
                        col <= '0;
                        row <= (prow_p0 == ROW_LAST) ? '0 : prow_p0 + 1'b1;
                    end else begin
                        col <= pcol_p0 + 1'b1;
                        row <= prow_p0;
                    end
                end else begin
                    ch  <= pch_p0 + 1'b1;
                    col <= pcol_p0;
                    row <= prow_p0;
                end
            end
        end
    end

    // Realign wipes every channel first; the current channel is then rewritten.
    always_ff @(posedge clk) begin
        if (!rst) begin
            expv <= '0;
            for (int i = 0; i < NCH; i++) begin
                acc[i]  <= '0;
                expd[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (realign_p0) begin
                    acc[i]  <= '0;
                    expd[i] <= '0;
                    expv[i] <= 1'b0;
                end
                if (proc_p0 && pch_p0 == CHW'(i)) begin
                    acc[i] <= last_p0 ? '0 : bip_p0;
                    if (last_p0) begin
                        expd[i] <= bip_p0;
                        expv[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // stage p1: registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            tug3dout   <= '0;
            dout_ch    <= '0;
            data_vld   <= 1'b0;
            tug3bip8   <= '0;
            bip_ch     <= '0;
            bip_vld    <= 1'b0;
            bip_errcnt <= '0;
            err_vld    <= 1'b0;
            realign    <= 1'b0;
        end else begin
            data_vld <= proc_p0 & (pcol_p0 != '0);
            bip_vld  <= last_p0;
            err_vld  <= chk_p0;
            realign  <= realign_p0;
            if (proc_p0 && pcol_p0 != '0) begin
                tug3dout <= tug3din;
                dout_ch  <= pch_p0;
            end
            if (last_p0) begin
                tug3bip8 <= bip_p0;
                bip_ch   <= pch_p0;
            end
            if (chk_p0) begin
                bip_errcnt <= popcount(expd[pch_p0] ^ tug3din);
                bip_ch     <= pch_p0;
            end
        end
    end

endmodule

// File: tb/tb_tug3_demux_rx.sv
// Scoreboard bench for tug3_demux_rx: a frame-position model queues expected
// payload, BIP and error-count outputs as bytes are driven.
module tb_tug3_demux_rx;

    localparam int NCH  = 3;
    localparam int NCOL = 86;
    localparam int NROW = 9;
    localparam int FB   = NCH * NCOL * NROW;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       rxsof = 1'b0;
    logic [7:0] tug3din = 8'h00;
    logic [7:0] tug3dout;
    logic [1:0] dout_ch;
    logic       data_vld;
    logic [7:0] tug3bip8;
    logic [1:0] bip_ch;
    logic       bip_vld;
    logic [3:0] bip_errcnt;
    logic       err_vld;
    logic       realign;
    logic       in_sync;

    tug3_demux_rx #(.WIDTH(8), .NCH(NCH), .NCOL(NCOL), .NROW(NROW),
                    .BIP_ROW(0), .BIP_COL(1)) dut (
        .clk(clk), .rst(rst), .en(en), .rxsof(rxsof), .tug3din(tug3din),
        .tug3dout(tug3dout), .dout_ch(dout_ch), .data_vld(data_vld),
        .tug3bip8(tug3bip8), .bip_ch(bip_ch), .bip_vld(bip_vld),
        .bip_errcnt(bip_errcnt), .err_vld(err_vld), .realign(realign),
        .in_sync(in_sync)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [9:0] q_data[$];
    logic [9:0] q_bip[$];
    logic [5:0] q_err[$];
    int         exp_rea = 0;

    logic [7:0] m_acc[NCH];
    logic [7:0] m_exp[NCH];
    bit         m_expv[NCH];
    int         m_pos = 0;
    bit         m_sync = 0;

    int         n_data[NCH];
    int         n_bip = 0, n_err = 0, n_rea = 0;
    logic [7:0] obs_bip[NCH];
    logic [3:0] obs_err[NCH];
    logic [7:0] saved_bip[NCH];
    logic       en_q = 1'b0;
    logic [9:0] mon_e10;
    logic [5:0] mon_e6;

    always @(posedge clk) en_q <= en;

    always @(negedge clk) begin
        if (data_vld === 1'b1) begin
            n_data[dout_ch]++;
            checks++;
            if (q_data.size() == 0) begin
                errors++;
                $display("FAIL data_extra got ch=%0d d=%02h required none", dout_ch, tug3dout);
            end else begin
                mon_e10 = q_data.pop_front();
                if ({dout_ch, tug3dout} !== mon_e10) begin
                    errors++;
                    $display("FAIL data got ch=%0d d=%02h required ch=%0d d=%02h",
                             dout_ch, tug3dout, mon_e10[9:8], mon_e10[7:0]);
                end
            end
        end
        if (bip_vld === 1'b1) begin
            n_bip++;
            obs_bip[bip_ch] = tug3bip8;
            checks++;
            if (q_bip.size() == 0) begin
                errors++;
                $display("FAIL bip_extra got ch=%0d bip=%02h required none", bip_ch, tug3bip8);
            end else begin
                mon_e10 = q_bip.pop_front();
                if ({bip_ch, tug3bip8} !== mon_e10) begin
                    errors++;
                    $display("FAIL bip got ch=%0d bip=%02h required ch=%0d bip=%02h",
                             bip_ch, tug3bip8, mon_e10[9:8], mon_e10[7:0]);
                end
            end
        end
        if (err_vld === 1'b1) begin
            n_err++;
            obs_err[bip_ch] = bip_errcnt;
            checks++;
            if (q_err.size() == 0) begin
                errors++;
                $display("FAIL err_extra got ch=%0d cnt=%0d required none", bip_ch, bip_errcnt);
            end else begin
                mon_e6 = q_err.pop_front();
                if ({bip_ch, bip_errcnt} !== mon_e6) begin
                    errors++;
                    $display("FAIL errcnt got ch=%0d cnt=%0d required ch=%0d cnt=%0d",
                             bip_ch, bip_errcnt, mon_e6[5:4], mon_e6[3:0]);
                end
            end
        end
        if (realign === 1'b1) begin
            n_rea++;
            checks++;
            if (exp_rea == 0) begin
                errors++;
                $display("FAIL realign_extra got 1 required 0");
            end else exp_rea--;
        end
        if (en_q === 1'b0) begin
            checks++;
            if ((data_vld | bip_vld | err_vld | realign) === 1'b1) begin
                errors++;
                $display("FAIL idle_pulse got dv=%b bv=%b ev=%b ra=%b required 0",
                         data_vld, bip_vld, err_vld, realign);
            end
        end
    end

    task automatic model_reset();
        m_sync = 0;
        m_pos  = 0;
        for (int i = 0; i < NCH; i++) begin
            m_acc[i] = 8'h00; m_exp[i] = 8'h00; m_expv[i] = 0;
        end
    endtask

    task automatic model_byte(input logic s, input logic [7:0] d);
        int c, col, row;
        logic [1:0] c2;
        if (s) begin
            if (m_sync && m_pos != 0) begin
                exp_rea++;
                for (int i = 0; i < NCH; i++) begin
                    m_acc[i] = 8'h00; m_expv[i] = 0;
                end
            end
            m_pos  = 0;
            m_sync = 1;
        end
        if (m_sync) begin
            c   = m_pos % NCH;
            col = (m_pos / NCH) % NCOL;
            row = m_pos / (NCH * NCOL);
            c2  = 2'(c);
            if (col != 0) q_data.push_back({c2, d});
            if (row == 0 && col == 1 && m_expv[c])
                q_err.push_back({c2, 4'($countones(m_exp[c] ^ d))});
            m_acc[c] = m_acc[c] ^ d;
            if (row == NROW - 1 && col == NCOL - 1) begin
                q_bip.push_back({c2, m_acc[c]});
                m_exp[c]  = m_acc[c];
                m_expv[c] = 1;
                m_acc[c]  = 8'h00;
            end
            m_pos = (m_pos + 1) % FB;
        end
    endtask

    task automatic drive(input logic e, input logic s, input logic [7:0] d);
        en = e; rxsof = s; tug3din = d;
        if (e && rst) model_byte(s, d);
        @(posedge clk); #1;
    endtask

    task automatic flush();
        repeat (2) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic clr_obs();
        for (int i = 0; i < NCH; i++) n_data[i] = 0;
        n_bip = 0; n_err = 0; n_rea = 0;
    endtask

    task automatic send_frame(input int mode, input bit sof, input bit gap,
                              input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input int start, input int stop);
        int c, col, row;
        logic [7:0] d;
        for (int p = start; p < stop; p++) begin
            c   = p % NCH;
            col = (p / NCH) % NCOL;
            row = p / (NCH * NCOL);
            case (mode)
                0: d = 8'(p);
                1: d = (c == 1 && row == 4 && col == 10) ? 8'h5A : 8'h00;
                default: d = (row == 0 && col == 1) ? (c == 0 ? b0 : (c == 1 ? b1 : b2)) : 8'h00;
            endcase
            if (gap) repeat ($urandom_range(0, 1)) drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
            drive(1'b1, sof && p == 0, d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 8'h33);
        checks++;
        if ({tug3dout, dout_ch, data_vld, tug3bip8, bip_ch, bip_vld, bip_errcnt,
             err_vld, realign, in_sync} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got dout=%02h dv=%b bip=%02h bv=%b cnt=%0d ev=%b ra=%b sync=%b required all 0",
                     tug3dout, data_vld, tug3bip8, bip_vld, bip_errcnt, err_vld, realign, in_sync);
        end
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_increment();
        clr_obs();
        drive(1'b1, 1'b1, 8'd0);
        checks++;
        if (in_sync !== 1'b1) begin
            errors++; $display("FAIL in_sync_after_sof got %b required 1", in_sync);
        end
        drive(1'b1, 1'b0, 8'd1);
        drive(1'b1, 1'b0, 8'd2);
        checks++;
        if (data_vld !== 1'b0) begin
            errors++; $display("FAIL col0_suppressed got dv=%b required 0", data_vld);
        end
        drive(1'b1, 1'b0, 8'd3);
        checks++;
        if ({data_vld, dout_ch, tug3dout} !== {1'b1, 2'd0, 8'd3}) begin
            errors++;
            $display("FAIL first_data got dv=%b ch=%0d d=%02h required dv=1 ch=0 d=03",
                     data_vld, dout_ch, tug3dout);
        end
        send_frame(0, 1, 0, 8'h00, 8'h00, 8'h00, 4, FB);
        send_frame(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, FB);
        send_frame(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, FB);
        flush();
        for (int i = 0; i < NCH; i++) begin
            checks++;
            if (n_data[i] != 765 * 3) begin
                errors++; $display("FAIL data_count ch=%0d got %0d required %0d", i, n_data[i], 765 * 3);
            end
            saved_bip[i] = obs_bip[i];
        end
        checks++;
        if (n_bip != 9 || n_err != 6) begin
            errors++; $display("FAIL pulse_count got bip=%0d err=%0d required bip=9 err=6", n_bip, n_err);
        end
    endtask

    task automatic test_bip_values();
        clr_obs();
        send_frame(1, 1, 0, 8'h00, 8'h00, 8'h00, 0, FB);
        flush();
        checks++;
        if (n_bip != 3 || obs_bip[0] !== 8'h00 || obs_bip[1] !== 8'h5A || obs_bip[2] !== 8'h00) begin
            errors++;
            $display("FAIL bip_5a got n=%0d %02h %02h %02h required n=3 00 5a 00",
                     n_bip, obs_bip[0], obs_bip[1], obs_bip[2]);
        end
        clr_obs();
        send_frame(2, 1, 0, 8'h00, 8'h5A, 8'h00, 0, FB);
        flush();
        checks++;
        if (n_err != 3 || obs_err[0] !== 4'd0 || obs_err[1] !== 4'd0 || obs_err[2] !== 4'd0) begin
            errors++;
            $display("FAIL bip_match got n=%0d %0d %0d %0d required n=3 0 0 0",
                     n_err, obs_err[0], obs_err[1], obs_err[2]);
        end
        clr_obs();
        send_frame(2, 1, 0, 8'h00, 8'h5A, 8'h07, 0, FB);
        flush();
        checks++;
        if (n_err != 3 || obs_err[2] !== 4'd3 || obs_err[1] !== 4'd0) begin
            errors++;
            $display("FAIL bip_flip3 got n=%0d ch1=%0d ch2=%0d required n=3 ch1=0 ch2=3",
                     n_err, obs_err[1], obs_err[2]);
        end
    endtask

    task automatic test_gaps();
        clr_obs();
        send_frame(0, 1, 1, 8'h00, 8'h00, 8'h00, 0, FB);
        send_frame(0, 1, 1, 8'h00, 8'h00, 8'h00, 0, FB);
        flush();
        for (int i = 0; i < NCH; i++) begin
            checks++;
            if (n_data[i] != 765 * 2 || obs_bip[i] !== saved_bip[i]) begin
                errors++;
                $display("FAIL gap_ch%0d got n=%0d bip=%02h required n=%0d bip=%02h",
                         i, n_data[i], obs_bip[i], 765 * 2, saved_bip[i]);
            end
        end
        checks++;
        if (n_bip != 6 || n_err != 6) begin
            errors++; $display("FAIL gap_pulses got bip=%0d err=%0d required 6 6", n_bip, n_err);
        end
    endtask

    task automatic test_realign();
        send_frame(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, FB);
        send_frame(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 1000);
        clr_obs();
        send_frame(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, FB);
        flush();
        checks++;
        if (n_rea != 1 || n_err != 0 || n_bip != 3) begin
            errors++;
            $display("FAIL realign_frame got ra=%0d err=%0d bip=%0d required 1 0 3", n_rea, n_err, n_bip);
        end
        checks++;
        if (obs_bip[0] !== saved_bip[0] || obs_bip[2] !== saved_bip[2]) begin
            errors++;
            $display("FAIL realign_bip got %02h %02h required %02h %02h",
                     obs_bip[0], obs_bip[2], saved_bip[0], saved_bip[2]);
        end
        clr_obs();
        send_frame(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, FB);
        flush();
        checks++;
        if (n_err != 3 || n_bip != 3 || n_rea != 0) begin
            errors++;
            $display("FAIL after_realign got err=%0d bip=%0d ra=%0d required 3 3 0", n_err, n_bip, n_rea);
        end
    endtask

    task automatic test_midreset();
        send_frame(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 500);
        rst = 1'b0;
        drive(1'b1, 1'b0, 8'h11);
        checks++;
        if ({tug3dout, dout_ch, data_vld, tug3bip8, bip_ch, bip_vld, bip_errcnt,
             err_vld, realign, in_sync} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got dout=%02h dv=%b bip=%02h sync=%b required all 0",
                     tug3dout, data_vld, tug3bip8, in_sync);
        end
        rst = 1'b1;
        model_reset();
        clr_obs();
        send_frame(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 300);
        flush();
        checks++;
        if (n_data[0] + n_data[1] + n_data[2] != 0 || in_sync !== 1'b0) begin
            errors++;
            $display("FAIL hunt_ignore got n=%0d sync=%b required 0 0",
                     n_data[0] + n_data[1] + n_data[2], in_sync);
        end
        send_frame(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, FB);
        flush();
        checks++;
        if (n_data[1] != 765 || n_bip != 3 || n_err != 0 || in_sync !== 1'b1) begin
            errors++;
            $display("FAIL resync got n1=%0d bip=%0d err=%0d sync=%b required 765 3 0 1",
                     n_data[1], n_bip, n_err, in_sync);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_increment();
        test_bip_values();
        test_gaps();
        test_realign();
        test_midreset();
        checks++;
        if (q_data.size() != 0 || q_bip.size() != 0 || q_err.size() != 0 || exp_rea != 0) begin
            errors++;
            $display("FAIL leftover got data=%0d bip=%0d err=%0d ra=%0d required 0",
                     q_data.size(), q_bip.size(), q_err.size(), exp_rea);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tug3_demux_rx.md
Name: tug3_demux_rx

Overview:
- Receive-side TUG-3 demultiplexer with per-tributary BIP-8 generation and checking.
- Accepts a byte-interleaved stream of NCH TUG-3 tributaries (VC-4 payload with POH and fixed-stuff columns already removed) from the multiframe receive path.
- Aligns to frame start, de-interleaves and tags each byte with its channel, suppresses column-0 overhead, and outputs payload bytes.
- Computes BIP over each channel frame and compares it with the BIP byte carried in the following frame; reports the bit-error count.

Parameters:
- WIDTH, 8: data byte width.
- NCH, 3: number of interleaved TUG-3 channels (>=1).
- NCOL, 86: columns per channel row; column 0 is overhead.
- NROW, 9: rows per frame.
- BIP_ROW, 0: row of the received BIP byte within each channel frame.
- BIP_COL, 1: column of the received BIP byte (1..NCOL-1).
- CHW, $clog2(NCH) (min 1): width of the channel index.
- ECW, $clog2(WIDTH+1): width of the error count.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- en  in  1  input byte valid.
- rxsof  in  1  first byte of frame (channel 0, row 0, col 0); qualified by en.
- tug3din  in  WIDTH  input byte.
- tug3dout  out  WIDTH  payload byte.
- dout_ch  out  CHW  channel of tug3dout.
- data_vld  out  1  payload byte valid.
- tug3bip8  out  WIDTH  computed BIP of the completed channel frame.
- bip_ch  out  CHW  channel of tug3bip8.
- bip_vld  out  1  one-cycle pulse: tug3bip8 valid.
- bip_errcnt  out  ECW  popcount of (expected XOR received) BIP.
- err_vld  out  1  one-cycle pulse: bip_errcnt valid.
- realign  out  1  one-cycle pulse: rxsof arrived at an unexpected position.
- in_sync  out  1  level: frame alignment held.

Behaviour:
- Reset (rst=0 at clk edge):
  - All outputs go to 0.
  - Counters ch/col/row go to 0; BIP accumulators and expected registers clear; expected-valid flags clear.
  - State goes to HUNT.
  - Reset takes priority over every other input.
- States:
  - HUNT: only en & rxsof is observed; that byte is processed as position (0,0,0) and the state moves to SYNC.
  - SYNC: every en byte is processed. There is no exit except reset.
- Counter order per en byte: ch increments; on ch = NCH-1 it wraps and col increments; on col = NCOL-1 it wraps and row increments; on row = NROW-1 it wraps (end of frame). en=0 freezes everything.
- en & rxsof in SYNC:
  - If the counters are already at (0,0,0), this is normal and nothing special happens.
  - Otherwise:
    - Force the position to (0,0,0) and pulse realign.
    - Clear all accumulators and expected-valid flags.
    - Do not emit bip_vld for the truncated frames.
    - Process the byte normally as position (0,0,0).
- Data path (1-cycle registered latency):
  - For a byte at col >= 1, the next cycle has tug3dout = din, dout_ch = ch, data_vld = 1.
  - For col 0 bytes (H1-H3 and fixed stuff), data_vld = 0.
  - data_vld = 0 whenever en = 0.
- BIP accumulation:
  - acc[ch] ^= din for every byte of the channel frame, all columns, BIP byte included.
  - On the channel's last byte (row NROW-1, col NCOL-1), the next cycle has:
    - tug3bip8 = acc[ch] ^ din; bip_ch = ch; bip_vld = 1.
    - exp[ch] = the same value; expv[ch] = 1.
    - acc[ch] = 0.
- BIP check:
  - Applies to a byte at (BIP_ROW, BIP_COL) with expv[ch] = 1.
  - The next cycle has bip_errcnt = popcount(exp[ch] ^ din), err_vld = 1, and bip_ch = ch.
  - bip_vld and err_vld never coincide (distinct positions), so bip_ch is shared.
  - The first frame after sync or realign produces no err_vld.
- Between pulses, tug3bip8 and bip_errcnt hold their values; pulse outputs return to 0.
- in_sync = 1 in SYNC and 0 in HUNT.

Test Plan:
- Reset then stream 3 frames of 2322 bytes with en=1 and an incrementing byte pattern -> 765 data_vld per channel per frame; dout_ch cycles 0,1,2; first data byte appears one cycle after the first col-1 byte.
- All-zero payload with a 0x5A byte at ch1 (row 4, col 10) -> ch1 bip_vld with tug3bip8 = 0x5A; ch0 and ch2 report 0x00.
- Insert the correct BIP at (0,1) of each channel in frame 2 -> err_vld for 3 channels with bip_errcnt = 0. Flip 3 bits of ch2's BIP byte -> ch2 bip_errcnt = 3.
- Random en gaps (50% duty) on the same stream -> outputs identical to the gap-free run; no pulse occurs during en = 0.
- rxsof at byte 1000 of frame 2 -> realign pulse; no bip_vld for frame 2; no err_vld in the next frame; correct results from the frame after that.
- rst = 0 for one cycle mid-frame -> all outputs 0 and in_sync = 0; bytes are ignored until the next en & rxsof.
